// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared state encoding and constants for the div_seq divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PREP = 3'd1;
    localparam logic [2:0] c_ITER = 3'd2;
    localparam logic [2:0] c_FIX  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    // Sliced to the datapath width at the point of use
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

    function automatic int div_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] w_a_sh;
    logic [WIDTH:0] w_diff;

    // The partial remainder stays below the divisor, so the shifted value
    // needs one extra bit only for the compare, never for storage.
    assign w_a_sh = {a_i, q_i[WIDTH-1]};
    assign w_diff = w_a_sh - {1'b0, d_i};
    assign a_o    = w_diff[WIDTH] ? w_a_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign q_o    = {q_i[WIDTH-2:0], ~w_diff[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module      : div_seq
// Description : Iterative restoring DIV/DIVU sequencer with valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             busy
);

    localparam int c_CW = div_cnt_width(WIDTH);

    logic [2:0]       state_q, state_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [c_CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    assign w_dvd_mag = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    assign w_dvs_mag = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (qr_q),
        .d_i (dvs_q),
        .a_o (w_a_nxt),
        .q_o (w_q_nxt)
    );

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        a_d     = a_q;
        qr_d    = qr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            c_IDLE: begin
                if (div_valid) begin
                    sgn_d   = div_signed;
                    dvd_d   = div_dividend;
                    dvs_d   = div_divisor;
                    state_d = c_PREP;
                end
            end
            c_PREP: begin
                // Divisor register is reused to hold its magnitude from here on
                dvs_d  = w_dvs_mag;
                qneg_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                rneg_d = sgn_q & dvd_q[WIDTH-1];
                a_d    = '0;
                qr_d   = w_dvd_mag;
                cnt_d  = c_CW'(WIDTH);
                if (EARLY_ZERO && (dvs_q == '0)) begin
                    quo_d   = DIV_ZERO_QUOTIENT[WIDTH-1:0];
                    rem_d   = dvd_q;
                    state_d = c_DONE;
                end else begin
                    state_d = c_ITER;
                end
            end
            c_ITER: begin
                a_d   = w_a_nxt;
                qr_d  = w_q_nxt;
                cnt_d = cnt_q - c_CW'(1);
                if (cnt_q == c_CW'(1)) begin
                    state_d = c_FIX;
                end
            end
            c_FIX: begin
                quo_d   = qneg_q ? -qr_q : qr_q;
                rem_d   = rneg_q ? -a_q  : a_q;
                state_d = c_DONE;
            end
            c_DONE: begin
                if (out_ready) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            sgn_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            a_q     <= '0;
            qr_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else if (flush) begin
            // Result registers keep their last values; only out_valid qualifies them
            state_q <= c_IDLE;
            sgn_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            a_q     <= '0;
            qr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign div_ready     = (state_q == c_IDLE);
    assign out_valid     = (state_q == c_DONE);
    assign busy          = (state_q != c_IDLE);
    assign out_quotient  = quo_q;
    assign out_remainder = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module      : tb_div_seq
// Description : Self-checking bench for div_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         div_valid = 1'b0;
    logic         div_signed = 1'b0;
    logic [W-1:0] div_dividend = '0;
    logic [W-1:0] div_divisor = '0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic         div_ready;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(W), .EARLY_ZERO(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_valid     (div_valid),
        .div_ready     (div_ready),
        .div_signed    (div_signed),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {quotient, remainder} from plain integer arithmetic
    function automatic logic [2*W-1:0] ref_div(input bit s, input logic [W-1:0] n, input logic [W-1:0] d);
        longint a, b, q, r;
        if (d == '0) return {{W{1'b1}}, n};
        if (s) begin
            a = $signed(n);
            b = $signed(d);
        end else begin
            a = {32'd0, n};
            b = {32'd0, d};
        end
        q = a / b;
        r = a % b;
        return {q[W-1:0], r[W-1:0]};
    endfunction

    // Transaction-level model: idle / working (cycle countdown) / done
    int           m_st = 0;
    int           m_cd = 0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic [2*W-1:0] m_pend = '0;
    bit           m_chk = 1'b0;
    bit           mon_en = 1'b0;

    always @(posedge clk) begin
        mon_en <= 1'b1;
        if (rst) begin
            m_st  <= 0;
            m_q   <= '0;
            m_r   <= '0;
            m_chk <= 1'b1;
        end else if (flush) begin
            m_st  <= 0;
            m_chk <= 1'b0;
        end else begin
            case (m_st)
                0: if (div_valid) begin
                    m_pend <= ref_div(div_signed, div_dividend, div_divisor);
                    m_cd   <= (div_divisor == '0) ? 1 : W + 2;
                    m_st   <= 1;
                    m_chk  <= 1'b0;
                end
                1: begin
                    m_cd <= m_cd - 1;
                    if (m_cd == 1) begin
                        m_st <= 2;
                        {m_q, m_r} <= m_pend;
                    end
                end
                default: if (out_ready) begin
                    m_st  <= 0;
                    m_chk <= 1'b1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_div_ready", div_ready, m_st == 0);
            chk("mon_out_valid", out_valid, m_st == 2);
            chk("mon_busy", busy, m_st != 0);
            if (m_st == 2 || (m_st == 0 && m_chk)) begin
                chk("mon_quotient", out_quotient, m_q);
                chk("mon_remainder", out_remainder, m_r);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!div_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", div_ready, 1);
    endtask

    task automatic run_op(input bit s, input logic [W-1:0] n, input logic [W-1:0] d, input int hold,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input int elat);
        int c = 0;
        wait_ready();
        div_signed = s;
        div_dividend = n;
        div_divisor = d;
        div_valid = 1'b1;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                div_valid = 1'b0;
                div_dividend = $urandom;
                div_divisor = $urandom;
                div_signed = 1'($urandom);
            end
        end while (!out_valid && c < 100);
        chk("latency", c, elat);
        chk("quotient", out_quotient, eq);
        chk("remainder", out_remainder, er);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ready_after_done", div_ready, 1);
    endtask

    task automatic start_and_count(input int cycles);
        wait_ready();
        div_signed = 1'b0;
        div_dividend = 32'd200;
        div_divisor = 32'd3;
        div_valid = 1'b1;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            div_valid = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] gen_operand();
        case ($urandom % 6)
            0, 1: return $urandom;
            2:    return $urandom % 16;
            3:    return '0;
            4: begin
                case ($urandom % 4)
                    0:       return 32'h8000_0000;
                    1:       return 32'hFFFF_FFFF;
                    2:       return 32'h0000_0001;
                    default: return 32'h7FFF_FFFF;
                endcase
            end
            default: return -($urandom % 16);
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_div_ready", div_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_quotient", out_quotient, 0);
        chk("reset_remainder", out_remainder, 0);

        run_op(1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2, 35);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'd1, 35);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0, 35);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 32'h8000_0000, 35);
        run_op(1'b0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5, 2);

        // Flush during cycle 10 of an operation
        start_and_count(10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_div_ready", div_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        run_op(1'b0, 32'd9, 32'd3, 0, 32'd3, 32'd0, 35);

        // Flush and request together in IDLE must not accept
        div_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        flush = 1'b0;
        chk("flush_valid_no_accept", busy, 0);

        run_op(1'b0, 32'd1000, 32'd10, 5, 32'd100, 32'd0, 35);

        // Reset in the middle of iteration
        run_op(1'b0, 32'd77, 32'd5, 0, 32'd15, 32'd2, 35);
        start_and_count(15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_div_ready", div_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_quotient", out_quotient, 0);
        chk("midrst_remainder", out_remainder, 0);

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            div_valid = ($urandom % 10) < 7;
            div_signed = 1'($urandom);
            div_dividend = gen_operand();
            div_divisor = gen_operand();
            out_ready = 1'($urandom);
            flush = ($urandom % 80) == 0;
            rst = ($urandom % 500) == 0;
            @(negedge clk);
        end
        div_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (50) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
